addsub_pipe_nbit: RTL and testbench
===================================

# addsub_pipe_nbit

Parametrised, pipelined N-bit two's-complement adder/subtractor with a valid/ready stream interface and status flags. It is the successor to the 4-bit ripple add/sub unit. The carry chain is split into CHUNK-bit slices, one register stage per slice, so wide operands close timing at full clock rate. It sits between operand-fetch logic and any downstream consumer (ALU result mux, accumulator, DSP datapath).

## Interface
- WIDTH, 16, operand/result width in bits; must be ≥2 and a multiple of CHUNK
- CHUNK, 4, bits per pipeline slice; STAGES = WIDTH/CHUNK = latency in cycles
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat present
- in_ready  out  1  unit accepts a beat this cycle
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B
- add_n  in  1  0 = add (x+y), 1 = subtract (x−y)
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts result
- s  out  WIDTH  result
- c_out  out  1  carry out of MSB (subtract: 1 = no borrow)
- ovf  out  1  signed overflow
- zero  out  1  result (after saturation, if enabled) equals 0

## Operation
- Arithmetic: s = x + (y ^ {WIDTH{add_n}}) + add_n, modulo 2^WIDTH.
- Slice k (0 = LSB) adds bits [k·CHUNK +: CHUNK] with the carry registered from slice k−1. Slice 0 carry-in = add_n.
- Skew: x/y/add_n chunks for slice k are delayed k cycles on entry. Result chunks from slice k are delayed STAGES−1−k cycles. All bits of one beat emerge together.
- ovf = carry into MSB XOR carry out of MSB. Both carries come from the final slice.
- Per-stage valid bit. One global advance enable: adv = !out_valid | out_ready.
- in_ready = adv. A beat is accepted when in_valid & in_ready.
- When adv = 0, every pipeline register holds, including skew registers.
- in_valid while in_ready = 0 is ignored. The source must hold the data.
- Bubbles propagate as invalid stages. They do not squeeze out; throughput is 1 beat/cycle when out_ready is held high.
- Results leave in issue order, with no loss or duplication.

## Timing
- Reset (reset_n low, asynchronous) clears all valid bits and data, carry and skew registers to 0.
- While reset_n is low: out_valid=0, s=0, c_out=0, ovf=0, zero=0.
- in_ready = 1 from the first cycle after deassertion, since out_valid=0.
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+STAGES−1, i.e. it is valid during cycle n+STAGES−1.
- Latency is STAGES register stages, and the output register is the last slice stage.
- With CHUNK=WIDTH (STAGES=1), the unit is a single registered adder with latency 1.
- While out_valid=1 and out_ready=0, the outputs s/c_out/ovf/zero/out_valid hold stable.
- in_ready depends combinationally on out_ready. This is the only combinational in→out path.
- Reset mid-operation flushes all in-flight beats. No partial result is ever presented.
- Changing add_n between beats is legal. Each beat carries its own add_n through the skew.

## Configuration
- Macro ADDSUB_SATURATE_EN.
- Defined: when ovf=1, s is clamped.
  - Positive overflow (operand A sign 0) gives 0111…1.
  - Negative overflow gives 1000…0.
  - ovf and c_out still report the raw result. zero uses the clamped s.
  - Clamping is applied in the final stage and adds no latency.
- Undefined: s wraps modulo 2^WIDTH. No clamp logic is present.

## Test plan
All scenarios use WIDTH=16 and CHUNK=4 unless stated.
- Add: x=0x1234, y=0x0FFF, add_n=0 → after 4 cycles s=0x2233, c_out=0, ovf=0, zero=0.
- Subtract: 0x0005−0x0007 → s=0xFFFE, c_out=0, ovf=0. Then 0x1234−0x1234 → s=0x0000, c_out=1, zero=1.
- Overflow: 0x7FFF+0x0001 → ovf=1; s=0x8000, or 0x7FFF with ADDSUB_SATURATE_EN. Then 0x8000−0x0001 → ovf=1; s=0x7FFF, or 0x8000 with macro.
- Backpressure: 20 random beats, in_valid random, out_ready toggled pseudo-randomly → results match the reference model in order. No drops or duplicates. Outputs stay stable while stalled, and in_ready=0 whenever out_valid=1 & out_ready=0.
- Reset mid-stream: assert reset_n low with 3 beats in flight → out_valid=0 and s=0 immediately, with no clock needed. After release, the next beat 0x0001+0x0001 returns s=0x0002 after 4 cycles.
- WIDTH=8, CHUNK=8: 0xFF+0x01 add → s=0x00, c_out=1, zero=1, 1-cycle latency. Full throughput with out_ready=1.

Source files
------------

// File: rtl/addsub_pipe_nbit.sv
// Pipelined N-bit add/sub: carry chain cut into CHUNK-bit slices, one register stage per slice.
// Define ADDSUB_SATURATE_EN to clamp s on signed overflow; otherwise s wraps.
module addsub_pipe_nbit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             add_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = WIDTH / CHUNK;

  logic              adv;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] carry_vec;
  logic [WIDTH-1:0]  b_in;
  logic [WIDTH-1:0]  raw_next;
  logic [WIDTH-1:0]  s_next;
  logic              ovf_d;
  logic              ovf_q;
  logic              zero_q;

  // A single enable freezes the whole pipe, skew registers included, so stalled beats stay aligned.
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];
  assign b_in      = y ^ {WIDTH{add_n}};

`ifdef ADDSUB_SATURATE_EN
  logic sign_a;
  assign s_next = ovf_d ? (sign_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                        : raw_next;
`else
  assign s_next = raw_next;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_slice
      logic [CHUNK-1:0] a_cur;
      logic [CHUNK-1:0] b_cur;
      logic             cin;
      logic             carry_q;
      logic [CHUNK:0]   sum_full;
      // r_q[k] holds this slice's sum; later entries realign it with the MSB slice.
      logic [CHUNK-1:0] r_q [k:STAGES-1];

      if (k == 0) begin : g_entry
        assign a_cur = x[CHUNK-1:0];
        assign b_cur = b_in[CHUNK-1:0];
        assign cin   = add_n;
      end else begin : g_skew
        logic [CHUNK-1:0] a_q [1:k];
        logic [CHUNK-1:0] b_q [1:k];

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            for (int j = 1; j <= k; j++) begin
              a_q[j] <= '0;
              b_q[j] <= '0;
            end
          end else if (adv) begin
            a_q[1] <= x[k*CHUNK +: CHUNK];
            b_q[1] <= b_in[k*CHUNK +: CHUNK];
            for (int j = 2; j <= k; j++) begin
              a_q[j] <= a_q[j-1];
              b_q[j] <= b_q[j-1];
            end
          end
        end

        assign a_cur = a_q[k];
        assign b_cur = b_q[k];
        assign cin   = carry_vec[k-1];
      end

      assign sum_full     = {1'b0, a_cur} + {1'b0, b_cur} + {{CHUNK{1'b0}}, cin};
      assign carry_vec[k] = carry_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          carry_q <= 1'b0;
        end else if (adv) begin
          carry_q <= sum_full[CHUNK];
        end
      end

      if (k == STAGES-1) begin : g_msb
        assign raw_next[k*CHUNK +: CHUNK] = sum_full[CHUNK-1:0];
        // Carry into the MSB is recovered from the MSB sum bit and its operands.
        assign ovf_d = a_cur[CHUNK-1] ^ b_cur[CHUNK-1] ^ sum_full[CHUNK-1] ^ sum_full[CHUNK];
`ifdef ADDSUB_SATURATE_EN
        assign sign_a = a_cur[CHUNK-1];
`endif
      end else begin : g_low
        assign raw_next[k*CHUNK +: CHUNK] = r_q[STAGES-2];
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int j = k; j < STAGES; j++) r_q[j] <= '0;
        end else if (adv) begin
          if (k < STAGES-1) r_q[k] <= sum_full[CHUNK-1:0];
          for (int j = k + 1; j < STAGES - 1; j++) r_q[j] <= r_q[j-1];
          r_q[STAGES-1] <= s_next[k*CHUNK +: CHUNK];
        end
      end

      assign s[k*CHUNK +: CHUNK] = r_q[STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      ovf_q  <= ovf_d;
      zero_q <= (s_next == '0);
    end
  end

  assign c_out = carry_vec[STAGES-1];
  assign ovf   = ovf_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_addsub_pipe_nbit.sv
// Bench for addsub_pipe_nbit: directed cases, random backpressure against an arithmetic model,
// mid-stream reset, and a single-stage 8-bit instance. Honours ADDSUB_SATURATE_EN.
module tb_addsub_pipe_nbit;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        ovf;
    logic        z;
  } res_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, add_n, out_valid, out_ready, c_out, ovf, zero;
  logic [15:0] x, y, s;
  logic        in_valid8, in_ready8, add_n8, out_valid8, out_ready8, c_out8, ovf8, zero8;
  logic [7:0]  x8, y8, s8;

  int   checks = 0;
  int   failures = 0;
  int   issued = 0;
  int   got = 0;
  int   cyc = 0;
  int   stray = 0;
  logic last_acc = 1'b0;
  res_t exp_q[$];
  res_t e;

  addsub_pipe_nbit #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .add_n(add_n), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .c_out(c_out), .ovf(ovf), .zero(zero)
  );

  addsub_pipe_nbit #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .x(x8), .y(y8), .add_n(add_n8), .out_valid(out_valid8), .out_ready(out_ready8),
    .s(s8), .c_out(c_out8), .ovf(ovf8), .zero(zero8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Two's-complement arithmetic on plain integers.
  function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic sub);
    res_t   r;
    longint ua, ub, full, half, sa, sb, sr, raw;
    ua   = longint'(a);
    ub   = longint'(b);
    full = longint'(1) << w;
    half = full >> 1;
    sa   = (ua >= half) ? ua - full : ua;
    sb   = (ub >= half) ? ub - full : ub;
    sr   = sub ? sa - sb : sa + sb;
    raw  = (sub ? ua - ub : ua + ub) & (full - 1);
    r.ovf = (sr >= half) || (sr < -half);
    r.c   = sub ? (ua >= ub) : ((ua + ub) >= full);
`ifdef ADDSUB_SATURATE_EN
    if (r.ovf) raw = (sr > 0) ? half - 1 : half;
`endif
    r.s = 16'(raw);
    r.z = (raw == 0);
    return r;
  endfunction

  // Called at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic tick();
    logic        acc, pop, stall;
    logic [19:0] snap;
    res_t        ein, eout;
    #1;
    chk("in_ready_rule", in_ready, !out_valid || out_ready);
    acc   = in_valid && in_ready;
    pop   = out_valid && out_ready;
    stall = out_valid && !out_ready;
    snap  = {out_valid, s, c_out, ovf, zero};
    if (acc) ein = model(16, x, y, add_n);
    if (pop) begin
      chk("q_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        eout = exp_q.pop_front();
        chk("seq_s", s, eout.s);
        chk("seq_c_out", c_out, eout.c);
        chk("seq_ovf", ovf, eout.ovf);
        chk("seq_zero", zero, eout.z);
      end
      got++;
    end
    @(posedge clk);
    #1;
    if (acc) begin
      exp_q.push_back(ein);
      issued++;
    end
    last_acc = acc;
    if (stall) chk("stall_hold", {out_valid, s, c_out, ovf, zero}, snap);
  endtask

  task automatic issue_one(input logic [15:0] a, input logic [15:0] b, input logic sub);
    int lat;
    in_valid  = 1'b1;
    x         = a;
    y         = b;
    add_n     = sub;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 16) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 4);
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 0; x = 0; y = 0; add_n = 0; out_ready = 1;
    in_valid8 = 0; x8 = 0; y8 = 0; add_n8 = 0; out_ready8 = 1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_c_out", c_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 0);
    chk("rst8_out_valid", out_valid8, 0);
    chk("rst8_s", s8, 0);
    #10 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    issue_one(16'h1234, 16'h0FFF, 1'b0);
    chk("add_s", s, 16'h2233);
    chk("add_c_out", c_out, 0);
    chk("add_ovf", ovf, 0);
    chk("add_zero", zero, 0);

    issue_one(16'h0005, 16'h0007, 1'b1);
    chk("sub_neg_s", s, 16'hFFFE);
    chk("sub_neg_c_out", c_out, 0);
    chk("sub_neg_ovf", ovf, 0);

    issue_one(16'h1234, 16'h1234, 1'b1);
    chk("sub_eq_s", s, 16'h0000);
    chk("sub_eq_c_out", c_out, 1);
    chk("sub_eq_zero", zero, 1);

    issue_one(16'h7FFF, 16'h0001, 1'b0);
    chk("povf_ovf", ovf, 1);
    chk("povf_c_out", c_out, 0);
`ifdef ADDSUB_SATURATE_EN
    chk("povf_s", s, 16'h7FFF);
`else
    chk("povf_s", s, 16'h8000);
`endif

    issue_one(16'h8000, 16'h0001, 1'b1);
    chk("novf_ovf", ovf, 1);
    chk("novf_c_out", c_out, 1);
    chk("novf_zero", zero, 0);
`ifdef ADDSUB_SATURATE_EN
    chk("novf_s", s, 16'h8000);
`else
    chk("novf_s", s, 16'h7FFF);
`endif
    @(posedge clk);
    #1;

    // Random traffic with random backpressure; the source holds a beat until it is taken.
    issued = 0; got = 0; cyc = 0; last_acc = 1'b0; in_valid = 1'b0;
    while ((issued < 20 || got < 20) && cyc < 2000) begin
      if (!in_valid || last_acc) begin
        if (issued < 20 && $urandom_range(0, 2) != 0) begin
          in_valid = 1'b1;
          x = 16'($urandom);
          y = 16'($urandom);
          add_n = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 3) == 0) x = 16'h7FF0 | 16'($urandom_range(0, 15));
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("bp_in_time", cyc < 2000, 1);
    chk("bp_received", got, 20);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Back-to-back beats with out_ready held high.
    issued = 0; got = 0; out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        in_valid = 1'b1;
        x = 16'($urandom);
        y = 16'($urandom);
        add_n = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    chk("tput_issued", issued, 8);
    chk("tput_received", got, 8);

    // Reset with beats in flight and one on the output.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      x = 16'(16'h1111 * (i + 1));
      y = 16'h0101;
      add_n = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("rst_pre_valid", out_valid, 1);
    chk("rst_pre_s", s, 16'h1212);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_s", s, 0);
    chk("mid_rst_c_out", c_out, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_zero", zero, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) stray++;
      @(posedge clk);
      #1;
    end
    chk("flush_no_stray", stray, 0);
    issue_one(16'h0001, 16'h0001, 1'b0);
    chk("after_rst_s", s, 16'h0002);
    @(posedge clk);
    #1;

    // Single-stage 8-bit instance.
    in_valid8 = 1'b1; x8 = 8'hFF; y8 = 8'h01; add_n8 = 1'b0;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    chk("w8_latency1_valid", out_valid8, 1);
    chk("w8_s", s8, 8'h00);
    chk("w8_c_out", c_out8, 1);
    chk("w8_zero", zero8, 1);
    chk("w8_ovf", ovf8, 0);
    for (int i = 0; i < 10; i++) begin
      in_valid8 = 1'b1;
      x8 = 8'($urandom);
      y8 = 8'($urandom);
      add_n8 = 1'($urandom_range(0, 1));
      e = model(8, {8'h00, x8}, {8'h00, y8}, add_n8);
      #1;
      chk("w8_in_ready", in_ready8, 1);
      @(posedge clk);
      #1;
      chk("w8_tput_valid", out_valid8, 1);
      chk("w8_tput_s", s8, e.s);
      chk("w8_tput_c_out", c_out8, e.c);
      chk("w8_tput_ovf", ovf8, e.ovf);
      chk("w8_tput_zero", zero8, e.z);
    end
    in_valid8 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
